// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and the
// default values of the reset PC and the halt instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [15:0] HALT_WORD_DEF = 16'h0000;
  localparam logic [7:0]  RESET_PC_DEF  = 8'h00;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux.
//   pc             in   current PC
//   jump           in   absolute jump request (highest priority)
//   jump_target    in   absolute jump address
//   branch_taken   in   taken branch request
//   branch_offset  in   two's-complement offset relative to pc+1
//   pc_plus1       out  pc+1, wrapping modulo 2^ADDR_W
//   branch_target  out  pc+1+branch_offset, wrapping modulo 2^ADDR_W
//   next_pc        out  selected next PC
module next_pc_sel #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc
);

  // Truncating adds give the modulo-2^ADDR_W wrap; a negative offset is just
  // its two's-complement bit pattern added in.
  always_comb begin
    pc_plus1      = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    branch_target = pc_plus1 + branch_offset;
    next_pc       = pc_plus1;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch sequencer for the single-cycle core.
// Drives the instruction memory with the PC, forwards the fetched word to the
// decoder with a valid flag, selects the next PC, stops on the halt word and
// counts retired instructions (saturating).
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   leave IDLE, or restart from HALT
//   stall          in   hold PC and suppress retire this cycle
//   imem_addr      out  instruction memory address (= pc)
//   imem_data      in   combinational instruction memory read data
//   instr          out  word to decoder (= imem_data)
//   instr_valid    out  instr executes this cycle
//   pc             out  PC register
//   pc_plus1       out  pc+1 modulo 2^ADDR_W
//   jump           in   absolute jump request
//   jump_target    in   absolute jump address
//   branch_taken   in   resolved taken branch
//   branch_offset  in   branch offset relative to pc+1
//   halted         out  core stopped in HALT
//   retired        out  executed instruction count, saturating at 16'hFFFF
//
// state | meaning
// IDLE  | after reset; PC at RESET_PC, waiting for start
// RUN   | fetching and executing one instruction per cycle
// HALT  | halt word seen; PC frozen until start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic               halted,
  output logic [15:0]        retired
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] branch_target;
  logic              is_halt_word;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus1      (pc_plus1),
    .branch_target (branch_target),
    .next_pc       (next_pc)
  );

  assign is_halt_word = (imem_data == HALT_WORD);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = RESET_PC;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The halt word outranks stall so it is never marked valid; start is
        // deliberately not looked at here.
        if (is_halt_word) begin
          state_d = HALT;
        end else if (!stall) begin
          instr_valid = 1'b1;
          pc_d        = next_pc;
          if (retired_q != 16'hFFFF) begin
            retired_d = retired_q + 16'd1;
          end
        end
      end
      HALT: begin
        if (start) begin
          pc_d      = RESET_PC;
          retired_d = 16'd0;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = imem_data;
  assign halted    = (state_q == HALT);
  assign retired   = retired_q;

  // branch_target is exported by the mux for visibility; only next_pc is used.
  logic unused_ok;
  assign unused_ok = ^branch_target;

endmodule
